jt12_timer_bank: RTL

- Parametrised successor to the fixed two-timer (A/B) unit used by the FM top level.
- Holds NUM_TIMERS up-counting timers sharing one width, each with its own power-of-two prescaler, overflow flag and IRQ enable.
- Drives a single active-low IRQ.
- Sits between the register map (mmr) and the CPU interrupt line; overflow pulses also feed mode logic such as CSM.

---
 rtl/jt12_timer_bank.sv | 97 +++++++++
 1 files changed

// File: rtl/jt12_timer_bank.sv
// jt12_timer_bank: NUM_TIMERS up-counting timers with per-timer power-of-two
// prescalers, sticky overflow flags and a shared active-low IRQ.
// Optional macro JT12_TIMER_CSM_EN adds the csm_en input and the
// csm_keyon output, which together drive the CSM key-on pulse.
module jt12_timer_bank #(
   parameter int unsigned NUM_TIMERS = 2,
   parameter int unsigned CNT_W      = 10,
   parameter logic [31:0] PRESC      = 32'h40
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clk_en,
   input  logic [NUM_TIMERS*CNT_W-1:0] value,
   input  logic [NUM_TIMERS-1:0]       load,
   input  logic [NUM_TIMERS-1:0]       enable_irq,
   input  logic [NUM_TIMERS-1:0]       clr_flag,
   output logic [NUM_TIMERS-1:0]       flag,
   output logic [NUM_TIMERS-1:0]       overflow,
   output logic                        irq_n
`ifdef JT12_TIMER_CSM_EN
   ,
   input  logic                        csm_en,
   output logic                        csm_keyon
`endif
);

   for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_tmr
      // Prescaler wraps at PMASK; a zero exponent gives PMASK=0, so every
      // enabled clk_en is a tick.
      localparam logic [14:0] PMASK = 15'((32'd1 << PRESC[4*gi +: 4]) - 32'd1);

      logic [CNT_W-1:0] cnt;
      logic [14:0]      presc;
      logic             load_q;
      logic             load_edge;
      logic             tick;
      logic             ovf;

      // Load-edge detect and prescaler tick decode.
      always_comb begin
         load_edge = load[gi] & ~load_q;
         tick      = load[gi] & clk_en & (presc == PMASK);
      end

      // Counter/prescaler state; a load edge has priority over a tick.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt    <= '0;
            presc  <= '0;
            load_q <= 1'b0;
            ovf    <= 1'b0;
         end else begin
            load_q <= load[gi];
            ovf    <= 1'b0;
            if (load_edge) begin
               cnt   <= value[CNT_W*gi +: CNT_W];
               presc <= '0;
            end else if (load[gi] && clk_en) begin
               presc <= (presc + 15'd1) & PMASK;
               if (tick) begin
                  if (cnt == '1) begin
                     cnt <= value[CNT_W*gi +: CNT_W];
                     ovf <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
         end
      end

      assign overflow[gi] = ovf;
   end

   // Sticky flags: a set in the same cycle as a clear wins; irq_n follows one clk later.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag  <= '0;
         irq_n <= 1'b1;
      end else begin
         flag  <= (flag & ~clr_flag) | (overflow & enable_irq);
         irq_n <= ~|flag;
      end
   end

`ifdef JT12_TIMER_CSM_EN
   // One-clk key-on pulse following a timer 0 overflow in CSM mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         csm_keyon <= 1'b0;
      end else begin
         csm_keyon <= overflow[0] & csm_en & load[0];
      end
   end
`endif

endmodule
